// File: rtl/reg_display_scan_if.sv
// ---------------------------------------------------------------------------
// reg_display_scan_if
//   Register-file read port used by reg_display_scan.
//   rdAddr : 4-bit register select, driven by the scanner (master).
//   rdData : 16-bit combinational read data for rdAddr, driven by the
//            register file (slave).
// ---------------------------------------------------------------------------
interface reg_display_scan_if;
  logic [3:0]  rdAddr;
  logic [15:0] rdData;

  modport master (output rdAddr, input rdData);
  modport slave  (input rdAddr, output rdData);
endinterface

// File: rtl/reg_display_scan.sv
// ---------------------------------------------------------------------------
// reg_display_scan
//   Walks R0..R15 of a register file through a read port, latches each value
//   and shows it on a 4-digit multiplexed seven-segment display, with the
//   register index on 4 LEDs. Auto-advance after a dwell time, pause and
//   single-step are supported.
//
//   Optional feature: define DECIMAL_DISP_EN to show values in decimal. A
//   16-cycle sequential double-dabble (CONV state) follows FETCH; values
//   above 9999 show as four dashes. Without the macro the value is shown as
//   four hex digits and FETCH goes straight to SHOW.
//
// Parameters
//   DWELL_CYCLES   cycles each register stays displayed (>=2)
//   REFRESH_CYCLES cycles each digit is lit per scan (>=1)
//   LOOP           1: wrap R15->R0 and keep scanning, 0: stop after R15
//
// Ports
//   clk, reset  system clock, synchronous active-high reset
//   start       begin a scan at R0 (only honoured in IDLE)
//   pause       freeze the dwell counter while high
//   step        advance one register; honoured only while pause=1
//   rf          register-file read port (rdAddr out, rdData in)
//   seg         {g,f,e,d,c,b,a}, active-low
//   an          active-low one-hot digit enables, an[0] = least significant
//   dp          decimal point, active-low, held off
//   led         index of the register currently displayed
//   busy        high whenever the scanner is not IDLE
// ---------------------------------------------------------------------------
module reg_display_scan #(
  parameter int DWELL_CYCLES   = 50_000_000,
  parameter int REFRESH_CYCLES = 50_000,
  parameter bit LOOP           = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      step,
  reg_display_scan_if.master        rf,
  output logic [6:0]                seg,
  output logic [3:0]                an,
  output logic                      dp,
  output logic [3:0]                led,
  output logic                      busy
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_ADV   = 3'd4;
`ifdef DECIMAL_DISP_EN
  localparam logic [2:0] S_CONV  = 3'd2;
`endif

  logic [2:0]    state_q, state_d;
  logic [3:0]    addr_q,  addr_d;
  logic [3:0]    led_q,   led_d;
  logic [15:0]   val_q,   val_d;
  logic          blank_q, blank_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [RW-1:0] refr_q,  refr_d;
  logic [1:0]    dig_q,   dig_d;
`ifdef DECIMAL_DISP_EN
  // {BCD[19:0], binary[15:0]}; binary bits shift up into the BCD field.
  logic [35:0]   conv_q,  conv_d;
  logic [3:0]    bit_q,   bit_d;

  // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift.
  function automatic logic [35:0] dd_step(input logic [35:0] s);
    logic [35:0] t;
    t = s;
    for (int k = 0; k < 5; k++) begin
      if (t[16+4*k +: 4] >= 4'd5) t[16+4*k +: 4] = t[16+4*k +: 4] + 4'd3;
    end
    return t << 1;
  endfunction
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
`ifdef DECIMAL_DISP_EN
      default: s = 7'h3F;  // 4'hA marks an out-of-range value: dash
`else
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
`endif
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    led_d   = led_q;
    val_d   = val_q;
    blank_d = blank_q;
    dwell_d = dwell_q;
`ifdef DECIMAL_DISP_EN
    conv_d  = conv_q;
    bit_d   = bit_q;
`endif

    // Digit multiplexing runs in every state, independent of the scan.
    if (refr_q == RW'(REFRESH_CYCLES - 1)) begin
      refr_d = '0;
      dig_d  = dig_q + 2'd1;
    end else begin
      refr_d = refr_q + RW'(1);
      dig_d  = dig_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = 4'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
`ifdef DECIMAL_DISP_EN
        conv_d  = {20'd0, rf.rdData};
        bit_d   = 4'd0;
        state_d = S_CONV;
`else
        val_d   = rf.rdData;
        led_d   = addr_q;
        blank_d = 1'b0;
        dwell_d = '0;
        state_d = S_SHOW;
`endif
      end
`ifdef DECIMAL_DISP_EN
      S_CONV: begin
        conv_d = dd_step(conv_q);
        bit_d  = bit_q + 4'd1;
        if (bit_q == 4'd15) begin
          // A non-zero ten-thousands digit means the value exceeds 9999.
          val_d   = (conv_d[35:32] != 4'd0) ? 16'hAAAA : conv_d[31:16];
          led_d   = addr_q;
          blank_d = 1'b0;
          dwell_d = '0;
          state_d = S_SHOW;
        end
      end
`endif
      S_SHOW: begin
        // step only counts while paused, and the dwell counter only runs
        // while not paused, so the two can never cause a double advance.
        if (pause && step) begin
          dwell_d = '0;
          state_d = S_ADV;
        end else if (!pause) begin
          if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
            dwell_d = '0;
            state_d = S_ADV;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end
      S_ADV: begin
        if (addr_q == 4'hF && !LOOP) begin
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 4'd0;
      led_q   <= 4'd0;
      val_q   <= 16'd0;
      blank_q <= 1'b1;
      dwell_q <= '0;
      refr_q  <= '0;
      dig_q   <= 2'd0;
`ifdef DECIMAL_DISP_EN
      conv_q  <= 36'd0;
      bit_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      led_q   <= led_d;
      val_q   <= val_d;
      blank_q <= blank_d;
      dwell_q <= dwell_d;
      refr_q  <= refr_d;
      dig_q   <= dig_d;
`ifdef DECIMAL_DISP_EN
      conv_q  <= conv_d;
      bit_q   <= bit_d;
`endif
    end
  end

  logic [3:0] nib;
  assign nib       = val_q[{dig_q, 2'b00} +: 4];
  assign an        = blank_q ? 4'hF : ~(4'b0001 << dig_q);
  assign seg       = blank_q ? 7'h7F : seg_decode(nib);
  assign dp        = 1'b1;
  assign led       = led_q;
  assign busy      = (state_q != S_IDLE);
  assign rf.rdAddr = addr_q;

endmodule
